// File: rtl/alu_share_arbiter.sv
// Round-robin share of one multi-cycle 8-bit ALU between two requesters; tagged response channel.
// Optional ALU watchdog enabled by defining ALU_TIMEOUT_EN.
module alu_share_arbiter #(
  parameter int DW          = 8,
  parameter int OPW         = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           req1_ready,
  output logic           alu_start,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic           alu_done,
  input  logic [DW-1:0]  alu_result,
  output logic           rsp_valid,
  output logic           rsp_tag,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_err,
  input  logic           rsp_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } req_t;

  state_t state;
  logic   last_grant;
  logic   win;
  logic   grant_ok;
  req_t   win_req;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    win = 1'b0;
    case ({req1_valid, req0_valid})
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
  end

  assign grant_ok   = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = grant_ok && !win;
  assign req1_ready = grant_ok && win;
  assign win_req    = win ? req_t'{req1_op, req1_a, req1_b} : req_t'{req0_op, req0_a, req0_b};

`ifdef ALU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;
  logic          rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_tag    <= 1'b0;
      rsp_data   <= '0;
`ifdef ALU_TIMEOUT_EN
      tmo_cnt    <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            alu_op    <= win_req.op;
            alu_a     <= win_req.a;
            alu_b     <= win_req.b;
            rsp_tag   <= win;
            alu_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef ALU_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT: begin
          // A done arriving on the expiry cycle still delivers the real result.
          if (alu_done) begin
            rsp_data  <= alu_result;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef ALU_TIMEOUT_EN
            rsp_err_q <= 1'b0;
          end else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
            tmo_cnt   <= tmo_cnt + 1'b1;
            rsp_data  <= '0;
            rsp_err_q <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_tag;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: latency, round-robin, backpressure, timeout, reset abort, stray done.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       alu_start;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_done;
  logic [7:0] alu_result;
  logic       rsp_valid, rsp_tag, rsp_err, rsp_ready;
  logic [7:0] rsp_data;

  logic       alu_auto;
  logic       alu_done_m, alu_done_f;
  logic [7:0] res_m, res_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  // External 1-cycle ALU: 0 add, 1 sub, 2 and, 3 xor.
  always @(posedge clk) begin
    alu_done_m <= 1'b0;
    if (alu_auto && alu_start) begin
      alu_done_m <= 1'b1;
      case (alu_op)
        3'd0:    res_m <= alu_a + alu_b;
        3'd1:    res_m <= alu_a - alu_b;
        3'd2:    res_m <= alu_a & alu_b;
        3'd3:    res_m <= alu_a ^ alu_b;
        default: res_m <= 8'h00;
      endcase
    end
  end

  assign alu_done   = alu_done_m | alu_done_f;
  assign alu_result = alu_done_f ? res_f : res_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    rst = 1'b1; alu_auto = 1'b1; alu_done_f = 1'b0; res_f = 8'h00; res_m = 8'h00; alu_done_m = 1'b0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1'b1;
    do_reset();

    // Reset state
    #1;
    chk("rst_state_rsp_valid", rsp_valid, 0);
    chk("rst_state_alu_start", alu_start, 0);
    chk("rst_state_rsp_data", rsp_data, 0);
    chk("rst_state_ready0", req0_ready, 0);

    // 1. Single requester latency
    req0_valid = 1; req0_op = 3'd0; req0_a = 8'd3; req0_b = 8'd4;
    #1 chk("t1_ready_T", req0_ready, 1);
    chk("t1_ready1_T", req1_ready, 0);
    tick(); req0_valid = 0;
    #1;
    chk("t1_alu_start_T1", alu_start, 1);
    chk("t1_alu_op", alu_op, 0);
    chk("t1_alu_a", alu_a, 3);
    chk("t1_alu_b", alu_b, 4);
    tick();
    chk("t1_rsp_valid_T2", rsp_valid, 0);
    chk("t1_alu_start_T2", alu_start, 0);
    tick();
    chk("t1_rsp_valid_T3", rsp_valid, 1);
    chk("t1_rsp_tag", rsp_tag, 0);
    chk("t1_rsp_data", rsp_data, 7);
    chk("t1_rsp_err", rsp_err, 0);
    tick();
    chk("t1_rsp_valid_T4", rsp_valid, 0);

    // 2. Round robin under continuous contention
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_op = 3'd0; req0_a = 8'd10; req0_b = 8'd5;
    req1_valid = 1; req1_op = 3'd1; req1_a = 8'd20; req1_b = 8'd8;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("t2_g%0d_ready0", g), req0_ready, (g % 2) == 0);
      chk($sformatf("t2_g%0d_ready1", g), req1_ready, (g % 2) == 1);
      tick();
      chk($sformatf("t2_g%0d_issue_readys", g), {req0_ready, req1_ready}, 0);
      tick();
      chk($sformatf("t2_g%0d_wait_readys", g), {req0_ready, req1_ready}, 0);
      tick();
      chk($sformatf("t2_g%0d_rsp_valid", g), rsp_valid, 1);
      chk($sformatf("t2_g%0d_rsp_tag", g), rsp_tag, g % 2);
      chk($sformatf("t2_g%0d_rsp_data", g), rsp_data, (g % 2) ? 12 : 15);
      chk($sformatf("t2_g%0d_resp_readys", g), {req0_ready, req1_ready}, 0);
      tick();
    end
    req0_valid = 0; req1_valid = 0;

    // 3. Response backpressure
    do_reset();
    rsp_ready = 0;
    req0_valid = 1; req0_op = 3'd3; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1; req1_op = 3'd2; req1_a = 8'hAA; req1_b = 8'h0F;
    #1 chk("t3_ready0", req0_ready, 1);
    tick(); req0_valid = 0;
    #1 chk("t3_ready1_issue", req1_ready, 0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold%0d_valid", i), rsp_valid, 1);
      chk($sformatf("t3_hold%0d_tag", i), rsp_tag, 0);
      chk($sformatf("t3_hold%0d_data", i), rsp_data, 8'hCC);
      chk($sformatf("t3_hold%0d_readys", i), {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1;
    chk("t3_still_valid", rsp_valid, 1);
    tick();
    #1 chk("t3_ready1_after", req1_ready, 1);
    tick(); req1_valid = 0;
    tick();
    tick();
    chk("t3_r1_tag", rsp_tag, 1);
    chk("t3_r1_data", rsp_data, 8'h0A);
    tick();

    // 4. ALU never completes
    do_reset();
    alu_auto = 0;
`ifdef ALU_TIMEOUT_EN
    rsp_ready = 0;
    req0_valid = 1; req0_op = 3'd0; req0_a = 8'd1; req0_b = 8'd2;
    tick(); req0_valid = 0;
    tick();
    repeat (15) tick();
    chk("t4_no_rsp_before_expiry", rsp_valid, 0);
    tick();
    chk("t4_tmo_valid", rsp_valid, 1);
    chk("t4_tmo_err", rsp_err, 1);
    chk("t4_tmo_data", rsp_data, 0);
    chk("t4_tmo_tag", rsp_tag, 0);
    alu_done_f = 1; res_f = 8'h77;
    tick(); alu_done_f = 0;
    chk("t4_stray_data", rsp_data, 0);
    chk("t4_stray_err", rsp_err, 1);
    rsp_ready = 1;
    tick();
    chk("t4_drained", rsp_valid, 0);
`else
    req0_valid = 1; req0_op = 3'd0; req0_a = 8'd1; req0_b = 8'd2;
    tick(); req0_valid = 0;
    saw = 0;
    repeat (100) begin
      tick();
      if (rsp_valid) saw = 1;
    end
    chk("t4_no_rsp_100", saw, 0);
    chk("t4_err_tied", rsp_err, 0);
`endif

    // 5. Reset during WAIT aborts the op
    do_reset();
    alu_auto = 0; rsp_ready = 1;
    req0_valid = 1; req0_op = 3'd2; req0_a = 8'h11; req0_b = 8'h22;
    tick(); req0_valid = 0;
    chk("t5_alu_a_loaded", alu_a, 8'h11);
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("t5_rst_alu_start", alu_start, 0);
    chk("t5_rst_alu_op", alu_op, 0);
    chk("t5_rst_alu_a", alu_a, 0);
    chk("t5_rst_alu_b", alu_b, 0);
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    chk("t5_rst_rsp_data", rsp_data, 0);
    chk("t5_rst_rsp_tag", rsp_tag, 0);
    chk("t5_rst_rsp_err", rsp_err, 0);
    alu_done_f = 1; res_f = 8'h55;
    tick(); alu_done_f = 0;
    #1;
    chk("t5_late_done_valid", rsp_valid, 0);
    chk("t5_late_done_data", rsp_data, 0);
    chk("t5_late_done_start", alu_start, 0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("t5_next_grant0", req0_ready, 1);
    chk("t5_next_grant1", req1_ready, 0);
    tick(); req0_valid = 0; req1_valid = 0;

    // 6. Stray done in RESP
    do_reset();
    alu_auto = 1; rsp_ready = 0;
    req1_valid = 1; req1_op = 3'd0; req1_a = 8'h80; req1_b = 8'h7F;
    tick(); req1_valid = 0;
    tick();
    tick();
    chk("t6_rsp_data", rsp_data, 8'hFF);
    chk("t6_rsp_tag", rsp_tag, 1);
    alu_done_f = 1; res_f = 8'h99;
    tick(); alu_done_f = 0;
    chk("t6_stray_data", rsp_data, 8'hFF);
    chk("t6_stray_valid", rsp_valid, 1);
    rsp_ready = 1;
    tick();
    chk("t6_drained", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
